// File: rtl/lab1_sw_led_ctrl_if.sv
// Switch/LED sequencer bundle: raw switches and datapath result in, operands and LED status out.
interface lab1_sw_led_ctrl_if;
  logic [1:0] sw;
  logic [1:0] sw1;
  logic [2:0] dp_led;
  logic [1:0] op_a;
  logic [1:0] op_b;
  logic [2:0] led;
  logic       busy;
  logic       done;

  modport slave (
    input  sw, sw1, dp_led,
    output op_a, op_b, led, busy, done
  );

  modport master (
    output sw, sw1, dp_led,
    input  op_a, op_b, led, busy, done
  );
endinterface

// File: rtl/lab1_sw_led_ctrl.sv
// Sequencer for the 2+2 bit switch -> 3 bit LED datapath: sync, debounce, load, settle, show.
// Optional overflow blink of led[2] is enabled by defining LED_OVF_BLINK_EN.
module lab1_sw_led_ctrl #(
  parameter int DB_CYCLES   = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int BLINK_DIV   = 2
) (
  input  logic               clk,
  input  logic               rst,
  lab1_sw_led_ctrl_if.slave  bus
);
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int HW  = $clog2(HOLD_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [DBW-1:0] DB_MAX    = DBW'(DB_CYCLES);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_SHOW} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [3:0]     r_sync1;
  logic [3:0]     r_sync2;
  logic [3:0]     r_cand;
  logic [3:0]     r_stable;
  logic [DBW-1:0] r_cnt;
  logic           r_pending;
  logic [HW-1:0]  r_hold;
  logic [1:0]     r_op_a;
  logic [1:0]     r_op_b;
  logic [2:0]     r_led;
  logic           w_accept;
  logic           w_busy;
  logic           w_done;

  assign w_accept = (r_sync2 == r_cand) && (r_cnt == DB_LAST) && (r_cand != r_stable);

  // Synchroniser, debounce and the pending flag; a new acceptance beats the LOAD clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_cand    <= '0;
      r_cnt     <= '0;
      r_stable  <= '0;
      r_pending <= 1'b0;
    end else begin
      r_sync1 <= {bus.sw1, bus.sw};
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt != DB_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) begin
        r_stable <= r_cand;
      end
      if (w_accept) begin
        r_pending <= 1'b1;
      end else if (r_state == S_LOAD) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b1;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (r_pending) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: w_next = S_WAIT;
      S_WAIT: w_next = S_SHOW;
      S_SHOW: begin
        w_done = (r_hold == '0);
        if (r_hold == HOLD_LAST) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_a <= '0;
      r_op_b <= '0;
      r_hold <= '0;
    end else begin
      if (r_state == S_LOAD) begin
        r_op_a <= r_stable[1:0];
        r_op_b <= r_stable[3:2];
      end
      if (r_state == S_WAIT) begin
        r_hold <= '0;
      end else if (r_state == S_SHOW) begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end

`ifdef LED_OVF_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic          r_carry;
  logic [BW-1:0] r_blink_cnt;

  // led[2] keeps blinking past SHOW until the next result is latched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led       <= '0;
      r_carry     <= 1'b0;
      r_blink_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_led       <= bus.dp_led;
      r_carry     <= bus.dp_led[2];
      r_blink_cnt <= '0;
    end else if (r_carry) begin
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_led[2]    <= ~r_led[2];
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led <= '0;
    end else if (r_state == S_WAIT) begin
      r_led <= bus.dp_led;
    end
  end
`endif

  assign bus.op_a = r_op_a;
  assign bus.op_b = r_op_b;
  assign bus.led  = r_led;
  assign bus.busy = w_busy;
  assign bus.done = w_done;
endmodule
